uart_fifo_adapter: RTL and testbench



---
 rtl/uart_fifo_adapter_pkg.sv | 14 +
 rtl/uart_fifo_adapter_sync_fifo.sv | 56 +++++
 rtl/uart_fifo_adapter.sv | 116 +++++++++++
 tb/tb_uart_fifo_adapter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_fifo_adapter_pkg.sv
// Shared definitions for the UART FIFO adapter: default FIFO depth and the
// transmit sequencer state encoding.
package uart_fifo_adapter_pkg;

  localparam int UART_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LAUNCH,
    TX_SETTLE,
    TX_DRAIN
  } tx_state_e;

endpackage

// File: rtl/uart_fifo_adapter_sync_fifo.sv
// Single-clock show-ahead FIFO. A push on a full FIFO lands only when a pop
// frees the slot in the same cycle; storage is deliberately left unreset.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             push_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      level_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_ONE;
      if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = (level_q == FULL_LVL);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule

// File: rtl/uart_fifo_adapter.sv
// Byte FIFOs between a host and a UART controller: TX queue drained by a
// four-state send sequencer, RX queue filled from an ack-handshaked receiver.
module uart_fifo_adapter
  import uart_fifo_adapter_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    tx_wdata,
  input  logic          tx_we,
  output logic          tx_full,
  output logic [AW:0]   tx_level,
  output logic [7:0]    rx_rdata,
  input  logic          rx_re,
  output logic          rx_empty,
  output logic [AW:0]   rx_level,
  output logic          rx_overrun,
  input  logic          overrun_clr,
  output logic [7:0]    uart_send_data,
  output logic          uart_send,
  input  logic          uart_send_busy,
  input  logic [7:0]    uart_rev_data,
  input  logic          uart_rev_data_valid,
  output logic          uart_rev_data_invalid
);

  tx_state_e   state_q, state_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic [7:0]  tx_head;
  logic        tx_empty, tx_pop, tx_push;
  logic        rx_full, rx_pop, rx_accept, rx_drop;
  logic        ack_q, held_q, overrun_q;

  assign tx_push = tx_we && !tx_full;

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wdata_i (tx_wdata),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .rdata_o (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .level_o (tx_level)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wdata_i (uart_rev_data),
    .push_i  (rx_accept),
    .pop_i   (rx_re),
    .rdata_o (rx_rdata),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .level_o (rx_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= TX_IDLE;
      tx_byte_q <= '0;
    end else begin
      state_q   <= state_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tx_byte_d = tx_byte_q;
    tx_pop    = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_pop    = 1'b1;
          tx_byte_d = tx_head;
          state_d   = TX_LAUNCH;
        end
      end
      TX_LAUNCH: state_d = TX_SETTLE;
      // busy only rises the cycle after the send pulse, so skip one cycle
      TX_SETTLE: state_d = TX_DRAIN;
      TX_DRAIN:  if (!uart_send_busy) state_d = TX_IDLE;
      default:   state_d = TX_IDLE;
    endcase
  end

  assign uart_send      = (state_q == TX_LAUNCH);
  assign uart_send_data = tx_byte_q;

  // held_q remembers that the byte behind a still-high valid was already
  // taken, so a controller that keeps valid up after the ack is not re-read.
  assign rx_pop    = rx_re && !rx_empty;
  assign rx_accept = uart_rev_data_valid && !ack_q && !held_q;
  assign rx_drop   = rx_accept && rx_full && !rx_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q     <= 1'b0;
      held_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      ack_q     <= rx_accept;
      held_q    <= uart_rev_data_valid && (held_q || rx_accept);
      overrun_q <= rx_drop || (overrun_q && !overrun_clr);
    end
  end

  assign uart_rev_data_invalid = ack_q;
  assign rx_overrun            = overrun_q;

endmodule

// File: tb/tb_uart_fifo_adapter.sv
// Scoreboard bench for uart_fifo_adapter: queue-based reference model,
// a busy-generating controller model, and negedge monitors.
module tb_uart_fifo_adapter;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    tx_wdata = '0;
  logic          tx_we = 1'b0;
  logic          tx_full;
  logic [AW:0]   tx_level;
  logic [7:0]    rx_rdata;
  logic          rx_re = 1'b0;
  logic          rx_empty;
  logic [AW:0]   rx_level;
  logic          rx_overrun;
  logic          overrun_clr = 1'b0;
  logic [7:0]    uart_send_data;
  logic          uart_send;
  logic          uart_send_busy = 1'b0;
  logic [7:0]    uart_rev_data = '0;
  logic          uart_rev_data_valid = 1'b0;
  logic          uart_rev_data_invalid;

  int n_chk = 0;
  int n_fail = 0;
  byte unsigned exp_tx[$];
  byte unsigned exp_rx[$];
  bit  exp_ovr = 1'b0;
  int  n_sent = 0;
  int  n_ack = 0;
  bit  prev_send = 1'b0;
  bit  prev_ack = 1'b0;
  int  busy_len = 2;
  int  busy_cnt = 0;
  bit  busy_rand = 1'b0;

  uart_fifo_adapter #(.DEPTH(DEPTH)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .tx_wdata              (tx_wdata),
    .tx_we                 (tx_we),
    .tx_full               (tx_full),
    .tx_level              (tx_level),
    .rx_rdata              (rx_rdata),
    .rx_re                 (rx_re),
    .rx_empty              (rx_empty),
    .rx_level              (rx_level),
    .rx_overrun            (rx_overrun),
    .overrun_clr           (overrun_clr),
    .uart_send_data        (uart_send_data),
    .uart_send             (uart_send),
    .uart_send_busy        (uart_send_busy),
    .uart_rev_data         (uart_rev_data),
    .uart_rev_data_valid   (uart_rev_data_valid),
    .uart_rev_data_invalid (uart_rev_data_invalid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Controller model: busy rises the cycle after a send pulse.
  always @(posedge clk) begin
    #1;
    if (busy_cnt > 0) begin
      uart_send_busy = 1'b1;
      busy_cnt--;
    end else begin
      uart_send_busy = 1'b0;
    end
    if (uart_send === 1'b1)
      busy_cnt = busy_rand ? int'($urandom_range(0, 4)) : busy_len;
  end

  always @(negedge clk) begin
    if (uart_send === 1'b1) begin
      n_sent++;
      chk("send_pulse_width", {31'd0, prev_send}, 0);
      chk("send_while_busy", {31'd0, uart_send_busy}, 0);
      if (exp_tx.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_send: got 0x%0h expected no send", uart_send_data);
      end else begin
        chk("tx_byte", {24'd0, uart_send_data}, {24'd0, exp_tx.pop_front()});
      end
    end
    prev_send = (uart_send === 1'b1);
    if (uart_rev_data_invalid === 1'b1) begin
      n_ack++;
      chk("ack_pulse_width", {31'd0, prev_ack}, 0);
    end
    prev_ack = (uart_rev_data_invalid === 1'b1);
    if (rx_re && rx_empty === 1'b0) begin
      if (exp_rx.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rx_unexpected_data: got 0x%0h expected empty", rx_rdata);
      end else begin
        chk("rx_byte", {24'd0, rx_rdata}, {24'd0, exp_rx.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic write_one(input byte unsigned b);
    step();
    tx_wdata = b;
    tx_we = 1'b1;
    exp_tx.push_back(b);
    step();
    tx_we = 1'b0;
  endtask

  task automatic wait_tx_drain(input int bound);
    int i = 0;
    while (exp_tx.size() > 0 && i < bound) begin
      step();
      i++;
    end
    chk("tx_drain_timeout", exp_tx.size(), 0);
    repeat (8) step();
  endtask

  task automatic deliver(input byte unsigned b, input int hold, input bit with_read, input bit clr);
    int a0 = n_ack;
    bit drop;
    step();
    uart_rev_data = b;
    uart_rev_data_valid = 1'b1;
    rx_re = with_read;
    overrun_clr = clr;
    if (exp_rx.size() < DEPTH || (with_read && exp_rx.size() > 0)) begin
      exp_rx.push_back(b);
      drop = 1'b0;
    end else begin
      drop = 1'b1;
    end
    if (drop) exp_ovr = 1'b1;
    else if (clr) exp_ovr = 1'b0;
    for (int i = 1; i < hold; i++) begin
      step();
      rx_re = 1'b0;
      overrun_clr = 1'b0;
    end
    step();
    uart_rev_data_valid = 1'b0;
    rx_re = 1'b0;
    overrun_clr = 1'b0;
    uart_rev_data = 8'($urandom);
    step();
    chk("ack_count", n_ack - a0, 1);
    chk("rx_level", {27'd0, rx_level}, exp_rx.size());
    chk("rx_overrun", {31'd0, rx_overrun}, {31'd0, exp_ovr});
    chk("rx_empty", {31'd0, rx_empty}, {31'd0, exp_rx.size() == 0});
  endtask

  task automatic read_rx();
    step();
    rx_re = 1'b1;
    step();
    rx_re = 1'b0;
    chk("rx_level_after_read", {27'd0, rx_level}, exp_rx.size());
  endtask

  task automatic clear_overrun();
    step();
    overrun_clr = 1'b1;
    exp_ovr = 1'b0;
    step();
    overrun_clr = 1'b0;
    chk("overrun_cleared", {31'd0, rx_overrun}, {31'd0, exp_ovr});
  endtask

  initial begin
    int s0;
    byte unsigned b;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_tx_full", {31'd0, tx_full}, 0);
    chk("rst_tx_level", {27'd0, tx_level}, 0);
    chk("rst_rx_empty", {31'd0, rx_empty}, 1);
    chk("rst_rx_level", {27'd0, rx_level}, 0);
    chk("rst_rx_overrun", {31'd0, rx_overrun}, 0);
    chk("rst_uart_send", {31'd0, uart_send}, 0);
    chk("rst_send_data", {24'd0, uart_send_data}, 0);
    chk("rst_ack", {31'd0, uart_rev_data_invalid}, 0);
    rst_n = 1'b1;

    // Single byte latency: write at cycle 0, send pulse at cycle 2.
    busy_len = 3;
    s0 = n_sent;
    step();
    tx_wdata = 8'h55;
    tx_we = 1'b1;
    exp_tx.push_back(8'h55);
    step();
    tx_we = 1'b0;
    chk("latency_cycle1_send", {31'd0, uart_send}, 0);
    step();
    chk("latency_cycle2_send", {31'd0, uart_send}, 1);
    chk("latency_send_data", {24'd0, uart_send_data}, 8'h55);
    repeat (10) step();
    chk("single_send_pulse", n_sent - s0, 1);
    chk("send_data_stable", {24'd0, uart_send_data}, 8'h55);

    // Fill the TX FIFO while the sequencer waits on a long busy.
    busy_len = 60;
    write_one(8'hEE);
    repeat (4) step();
    for (int i = 1; i <= 16; i++) begin
      step();
      tx_wdata = 8'(i);
      tx_we = 1'b1;
      exp_tx.push_back(8'(i));
    end
    step();
    tx_we = 1'b0;
    chk("tx_level_full", {27'd0, tx_level}, 16);
    chk("tx_full_set", {31'd0, tx_full}, 1);
    busy_len = 2;
    step();
    tx_wdata = 8'h99;
    tx_we = 1'b1;
    step();
    tx_we = 1'b0;
    chk("tx_level_after_drop", {27'd0, tx_level}, 16);
    chk("tx_full_after_drop", {31'd0, tx_full}, 1);
    wait_tx_drain(1000);
    chk("tx_last_byte", {24'd0, uart_send_data}, 8'h10);
    chk("tx_level_drained", {27'd0, tx_level}, 0);

    // Random TX traffic with random busy lengths.
    busy_rand = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      if ($urandom_range(0, 1) == 1 && exp_tx.size() < DEPTH) begin
        b = 8'($urandom);
        tx_wdata = b;
        tx_we = 1'b1;
        exp_tx.push_back(b);
      end else begin
        tx_we = 1'b0;
      end
    end
    step();
    tx_we = 1'b0;
    wait_tx_drain(1000);

    // RX: held valid yields a single push and ack.
    deliver(8'hA3, 5, 1'b0, 1'b0);
    chk("rx_head_a3", {24'd0, rx_rdata}, 8'hA3);
    read_rx();

    // RX overflow, set-wins-over-clear, then clear.
    for (int i = 0; i < DEPTH; i++)
      deliver(8'($urandom), int'($urandom_range(1, 3)), 1'b0, 1'b0);
    deliver(8'h77, 2, 1'b0, 1'b0);
    deliver(8'h78, 1, 1'b0, 1'b1);
    clear_overrun();

    // Push coincident with a host pop at full level.
    deliver(8'h5A, 2, 1'b1, 1'b0);
    chk("rx_full_level_kept", {27'd0, rx_level}, 16);
    while (exp_rx.size() > 0) read_rx();
    read_rx();

    // Random RX traffic.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 1) == 1)
        deliver(8'($urandom), int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 5) == 0));
      else
        read_rx();
    end
    while (exp_rx.size() > 0) read_rx();
    if (exp_ovr) clear_overrun();

    // Reset during DRAIN with three bytes queued.
    busy_rand = 1'b0;
    busy_len = 40;
    write_one(8'hA0);
    repeat (4) step();
    for (int i = 0; i < 3; i++) begin
      step();
      tx_wdata = 8'hB1 + 8'(i);
      tx_we = 1'b1;
      exp_tx.push_back(8'hB1 + 8'(i));
    end
    step();
    tx_we = 1'b0;
    chk("tx_level_before_reset", {27'd0, tx_level}, 3);
    rst_n = 1'b0;
    exp_tx.delete();
    exp_rx.delete();
    exp_ovr = 1'b0;
    step();
    chk("reset_tx_level", {27'd0, tx_level}, 0);
    chk("reset_tx_full", {31'd0, tx_full}, 0);
    chk("reset_uart_send", {31'd0, uart_send}, 0);
    chk("reset_send_data", {24'd0, uart_send_data}, 0);
    chk("reset_rx_level", {27'd0, rx_level}, 0);
    step();
    rst_n = 1'b1;
    s0 = n_sent;
    repeat (50) step();
    chk("no_send_after_reset", n_sent - s0, 0);
    busy_len = 2;
    write_one(8'h3C);
    wait_tx_drain(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
